car_motion_ctrl: RTL

Velocity-based successor to the car position controller. It turns held direction buttons into per-axis acceleration, speed saturation and friction decay, all paced by a frame divider. Edge behaviour is selectable: clamp, wrap or bounce. It lives in the clk_sys domain and feeds signed displacement from screen centre to the framebuffer car renderer.

---
 rtl/car_motion_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/car_motion_ctrl.sv
// car_motion_ctrl
// Velocity-based car motion controller for the framebuffer car renderer.
// Held direction buttons accelerate each axis. Speed saturates at MAX_SPEED,
// and an idle axis decays toward zero by FRICTION. Motion advances once every
// FRAME_DIV frame ticks. Screen edges clamp, wrap or bounce, selected by EDGE_MODE.
//
// Ports
//   clk          system clock (clk_sys)
//   rst_n        synchronous active-low reset
//   frame_tick   one-cycle pulse per frame
//   up_held, down_held, left_held, right_held   debounced button levels
//   center_reset recentre request: zeroes position, velocity and the divider
//   dx, dy       signed displacement of the car centre from the screen centre
//   vx, vy       signed velocity, in px per move tick
//   hit_x, hit_y one-cycle pulse when that axis met a boundary on a move tick
//   moving       high while either velocity is nonzero
module car_motion_ctrl #(
  parameter int W         = 320,
  parameter int H         = 240,
  parameter int WB        = 88,
  parameter int HB        = 44,
  parameter int POS_W     = 12,
  parameter int FRAME_DIV = 2,
  parameter int ACCEL     = 1,
  parameter int MAX_SPEED = 4,
  parameter int FRICTION  = 1,
  parameter int EDGE_MODE = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    frame_tick,
  input  logic                    up_held,
  input  logic                    down_held,
  input  logic                    left_held,
  input  logic                    right_held,
  input  logic                    center_reset,
  output logic signed [POS_W-1:0] dx,
  output logic signed [POS_W-1:0] dy,
  output logic signed [POS_W-1:0] vx,
  output logic signed [POS_W-1:0] vy,
  output logic                    hit_x,
  output logic                    hit_y,
  output logic                    moving
);

  localparam int DX_MAX = W / 2 - WB / 2;
  localparam int DY_MAX = H / 2 - HB / 2;
  localparam int SPAN_X = 2 * DX_MAX + 1;
  localparam int SPAN_Y = 2 * DY_MAX + 1;
  // The divider keeps at least one bit, even when every frame is a move tick.
  localparam int CNT_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  typedef struct packed {
    logic signed [POS_W-1:0] p;
    logic signed [POS_W-1:0] v;
    logic                    hit;
  } axis_t;

  // One axis update. Arithmetic runs one bit wider than the outputs, so
  // p + v never wraps before the bound check sees it.
  function automatic axis_t axis_step(
    input logic signed [POS_W-1:0] p,
    input logic signed [POS_W-1:0] v,
    input logic                    pos_btn,
    input logic                    neg_btn,
    input logic signed [POS_W:0]   bnd,
    input logic signed [POS_W:0]   span
  );
    logic signed [POS_W:0] acc, fr, ms, ve, vn, pn, pw, nv;
    axis_t r;
    acc = (POS_W+1)'(ACCEL);
    fr  = (POS_W+1)'(FRICTION);
    ms  = (POS_W+1)'(MAX_SPEED);
    ve  = {v[POS_W-1], v};
    if (pos_btn && !neg_btn) begin
      vn = ve + acc;
      if (vn > ms) vn = ms;
    end else if (neg_btn && !pos_btn) begin
      vn = ve - acc;
      if (vn < -ms) vn = -ms;
    end else if (ve > fr) begin
      vn = ve - fr;
    end else if (ve < -fr) begin
      vn = ve + fr;
    end else begin
      vn = '0;
    end
    pn    = {p[POS_W-1], p} + vn;
    pw    = pn;
    nv    = -vn;
    r.p   = pn[POS_W-1:0];
    r.v   = vn[POS_W-1:0];
    r.hit = 1'b0;
    if (pn > bnd || pn < -bnd) begin
      r.hit = 1'b1;
      case (EDGE_MODE)
        1: begin
          pw  = (pn > bnd) ? (pn - span) : (pn + span);
          r.p = pw[POS_W-1:0];
        end
        2: begin
          pw  = (pn > bnd) ? bnd : -bnd;
          r.p = pw[POS_W-1:0];
          r.v = nv[POS_W-1:0];
        end
        default: begin
          pw  = (pn > bnd) ? bnd : -bnd;
          r.p = pw[POS_W-1:0];
          r.v = '0;
        end
      endcase
    end
    return r;
  endfunction

  logic signed [POS_W-1:0] dx_q, dx_d, dy_q, dy_d, vx_q, vx_d, vy_q, vy_d;
  logic                    hit_x_q, hit_x_d, hit_y_q, hit_y_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    move_tick;
  axis_t                   ax_x, ax_y;

  assign move_tick = frame_tick && (cnt_q == CNT_W'(FRAME_DIV - 1));

  // Right and down are the positive directions.
  assign ax_x = axis_step(dx_q, vx_q, right_held, left_held,
                          (POS_W+1)'(DX_MAX), (POS_W+1)'(SPAN_X));
  assign ax_y = axis_step(dy_q, vy_q, down_held, up_held,
                          (POS_W+1)'(DY_MAX), (POS_W+1)'(SPAN_Y));

  always_comb begin
    cnt_d   = cnt_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    vx_d    = vx_q;
    vy_d    = vy_q;
    hit_x_d = 1'b0;
    hit_y_d = 1'b0;
    if (center_reset) begin
      cnt_d = '0;
      dx_d  = '0;
      dy_d  = '0;
      vx_d  = '0;
      vy_d  = '0;
    end else if (frame_tick) begin
      if (move_tick) begin
        cnt_d   = '0;
        dx_d    = ax_x.p;
        vx_d    = ax_x.v;
        hit_x_d = ax_x.hit;
        dy_d    = ax_y.p;
        vy_d    = ax_y.v;
        hit_y_d = ax_y.hit;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      vx_q    <= '0;
      vy_q    <= '0;
      hit_x_q <= 1'b0;
      hit_y_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      vx_q    <= vx_d;
      vy_q    <= vy_d;
      hit_x_q <= hit_x_d;
      hit_y_q <= hit_y_d;
    end
  end

  assign dx     = dx_q;
  assign dy     = dy_q;
  assign vx     = vx_q;
  assign vy     = vy_q;
  assign hit_x  = hit_x_q;
  assign hit_y  = hit_y_q;
  assign moving = (|vx_q) || (|vy_q);

endmodule
